// File: rtl/ar_pkg.sv
// ar_pkg: shared definitions for the ARINC-429 style receive decoder.
//   - line-rate encodings for the 2-bit Nvel input and their bit rates
//   - receiver state enumeration
//   - bit_period(): clocks per bit for a given system clock and rate code
//   - word geometry (WORD_BITS, LABEL_BITS)
package ar_pkg;

  localparam int WORD_BITS  = 32;
  localparam int LABEL_BITS = 8;

  // Nvel encodings; 2'b11 aliases the 100 kbit/s rate.
  localparam logic [1:0] RATE_12K5 = 2'b00;
  localparam logic [1:0] RATE_50K  = 2'b01;
  localparam logic [1:0] RATE_100K = 2'b10;

  localparam int BAUD_12K5 = 12_500;
  localparam int BAUD_50K  = 50_000;
  localparam int BAUD_100K = 100_000;

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,  // waiting for a long enough null gap
    ST_IDLE  = 2'd1,  // gap satisfied, waiting for the first bit
    ST_QWAIT = 2'd2,  // quarter-bit delay from an edge to the sample point
    ST_BIT   = 2'd3   // between samples, waiting for the next bit edge
  } rx_state_t;

  // Clocks per bit period. Arguments are elaboration constants apart from
  // the rate code, so this reduces to a small constant mux.
  function automatic int bit_period(input int f_clk, input logic [1:0] nvel);
    int per;
    case (nvel)
      RATE_12K5: per = f_clk / BAUD_12K5;
      RATE_50K:  per = f_clk / BAUD_50K;
      default:   per = f_clk / BAUD_100K;
    endcase
    return per;
  endfunction

endpackage

// File: rtl/ar_sync2.sv
// ar_sync2: two-flop synchronizer for one asynchronous line input.
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset, output clears to 0
//   d     - asynchronous input
//   q     - synchronized output (two clocks of latency)
module ar_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= 1'b0;
      q        <= 1'b0;
    end else begin
      meta_reg <= d;
      q        <= meta_reg;
    end
  end

endmodule

// File: rtl/ar_rx_decoder.sv
// ar_rx_decoder: ARINC-429 style bipolar return-to-zero line decoder.
// Recovers bit timing from the two line levels, assembles 32-bit words,
// checks odd parity and framing, and presents label/data with a one-cycle
// write strobe.
//
// Parameters:
//   F_CLK    - system clock frequency in Hz
//   GAP_BITS - null bit periods required before a word may start
// Ports:
//   clk      - system clock
//   Rn       - asynchronous active-low reset
//   inp1     - line "logic 1" level, asynchronous
//   inp0     - line "logic 0" level, asynchronous
//   Nvel     - rate select: 00 12.5k, 01 50k, 1x 100k bit/s
//   lbl_val  - label match value (label filter builds only)
//   lbl_mask - label match mask, 1 = compare bit (label filter builds only)
//   rx_adr   - received label, first bit on the line at rx_adr[7]
//   rx_dat   - word bits 9..32, parity bit at rx_dat[23]
//   ce_wr    - one-cycle strobe, rx_adr/rx_dat/par_err updated
//   par_err  - 1 when the delivered word has even parity
//   frm_err  - one-cycle strobe on a framing violation
//   busy     - 1 while a word is being received
//
// Build option: define AR_RX_LABEL_FILTER_EN to deliver only words whose
// label matches lbl_val under lbl_mask; otherwise every word is delivered.
module ar_rx_decoder
  import ar_pkg::*;
#(
  parameter int F_CLK    = 50_000_000,
  parameter int GAP_BITS = 2
) (
  input  logic                  clk,
  input  logic                  Rn,
  input  logic                  inp1,
  input  logic                  inp0,
  input  logic [1:0]            Nvel,
  input  logic [LABEL_BITS-1:0] lbl_val,
  input  logic [LABEL_BITS-1:0] lbl_mask,
  output logic [LABEL_BITS-1:0] rx_adr,
  output logic [23:0]           rx_dat,
  output logic                  ce_wr,
  output logic                  par_err,
  output logic                  frm_err,
  output logic                  busy
);

  // The single timer serves as the gap counter in SYNC and as the
  // time-since-edge counter during a word, so size it for the longer use.
  localparam int T_MAX   = F_CLK / BAUD_12K5;
  localparam int GAP_MAX = (GAP_BITS > 2) ? GAP_BITS : 2;
  localparam int CW      = $clog2(GAP_MAX * T_MAX + 1) + 1;
  localparam int BW      = $clog2(WORD_BITS) + 1;

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WORD_BITS - 1);

  logic s1;
  logic s0;

  rx_state_t             state_reg;
  logic [CW-1:0]         cnt_reg;
  logic [BW-1:0]         bit_cnt_reg;
  logic [WORD_BITS-1:0]  word_reg;
  logic [1:0]            rate_reg;
  logic                  prev_null_reg;
  logic                  armed_reg;

  logic                  line_null;
  logic                  edge_det;
  logic                  bit_ok;
  logic [WORD_BITS-1:0]  word_shift;
  logic [CW-1:0]         gap_lim;
  logic [CW-1:0]         t_word;
  logic [CW-1:0]         q_lim;
  logic [CW-1:0]         tout_lim;
  logic [LABEL_BITS-1:0] label_rev;
  logic                  label_ok;

  ar_sync2 u_sync1 (.clk(clk), .rst_n(Rn), .d(inp1), .q(s1));
  ar_sync2 u_sync0 (.clk(clk), .rst_n(Rn), .d(inp0), .q(s0));

  always_comb begin
    line_null  = ~s1 & ~s0;
    edge_det   = prev_null_reg & ~line_null;
    bit_ok     = s1 ^ s0;
    // New bits enter at the top so the first received bit ends at index 0.
    word_shift = {s1, word_reg[WORD_BITS-1:1]};
    // The gap follows the live rate; word timing uses the rate latched at
    // the word start so a mid-word Nvel change cannot disturb it.
    gap_lim    = CW'(GAP_BITS * bit_period(F_CLK, Nvel));
    t_word     = CW'(bit_period(F_CLK, rate_reg));
    q_lim      = t_word >> 2;
    tout_lim   = t_word + (t_word >> 1);
  end

  // The label is sent MSB first, so the first bit lands at the top.
  for (genvar gi = 0; gi < LABEL_BITS; gi++) begin : g_label_rev
    assign label_rev[LABEL_BITS-1-gi] = word_shift[gi];
  end

`ifdef AR_RX_LABEL_FILTER_EN
  assign label_ok = (((label_rev ^ lbl_val) & lbl_mask) == '0);
`else
  assign label_ok = 1'b1;
  logic unused_lbl;
  assign unused_lbl = ^{lbl_val, lbl_mask};
`endif

  always_ff @(posedge clk or negedge Rn) begin
    if (!Rn) begin
      state_reg     <= ST_SYNC;
      cnt_reg       <= '0;
      bit_cnt_reg   <= '0;
      word_reg      <= '0;
      rate_reg      <= RATE_12K5;
      prev_null_reg <= 1'b0;
      armed_reg     <= 1'b0;
      rx_adr        <= '0;
      rx_dat        <= '0;
      ce_wr         <= 1'b0;
      par_err       <= 1'b0;
      frm_err       <= 1'b0;
      busy          <= 1'b0;
    end else begin
      ce_wr         <= 1'b0;
      frm_err       <= 1'b0;
      prev_null_reg <= line_null;

      case (state_reg)
        ST_SYNC: begin
          if (!line_null) begin
            cnt_reg <= '0;
            // A new bit edge right after a delivered word means the gap
            // was too short; report it once per gap violation.
            if (edge_det && armed_reg) begin
              frm_err   <= 1'b1;
              armed_reg <= 1'b0;
            end
          end else if (cnt_reg >= gap_lim - CNT_ONE) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            armed_reg <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end

        ST_IDLE: begin
          if (!line_null) begin
            state_reg   <= ST_QWAIT;
            cnt_reg     <= '0;
            bit_cnt_reg <= '0;
            rate_reg    <= Nvel;
            busy        <= 1'b1;
          end
        end

        ST_QWAIT: begin
          if (cnt_reg >= q_lim - CNT_ONE) begin
            if (!bit_ok) begin
              frm_err   <= 1'b1;
              busy      <= 1'b0;
              armed_reg <= 1'b0;
              state_reg <= ST_SYNC;
              cnt_reg   <= '0;
            end else if (bit_cnt_reg == BIT_LAST) begin
              word_reg    <= word_shift;
              bit_cnt_reg <= bit_cnt_reg + BIT_ONE;
              busy        <= 1'b0;
              armed_reg   <= 1'b1;
              state_reg   <= ST_SYNC;
              cnt_reg     <= '0;
              if (label_ok) begin
                ce_wr   <= 1'b1;
                rx_adr  <= label_rev;
                rx_dat  <= word_shift[WORD_BITS-1:LABEL_BITS];
                par_err <= ~^word_shift;
              end
            end else begin
              word_reg    <= word_shift;
              bit_cnt_reg <= bit_cnt_reg + BIT_ONE;
              state_reg   <= ST_BIT;
              cnt_reg     <= cnt_reg + CNT_ONE;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end

        ST_BIT: begin
          // The timer keeps running from the last edge through QWAIT, so
          // the timeout is measured edge to edge.
          if (edge_det) begin
            state_reg <= ST_QWAIT;
            cnt_reg   <= '0;
          end else if (cnt_reg >= tout_lim - CNT_ONE) begin
            frm_err   <= 1'b1;
            busy      <= 1'b0;
            armed_reg <= 1'b0;
            state_reg <= ST_SYNC;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end

        default: begin
          state_reg <= ST_SYNC;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/ar_rx_decoder.md
# ar_rx_decoder

ARINC-429 style bipolar return-to-zero line decoder, the receive-side counterpart of the word transmitter that drives TXD1/TXD0. It takes the two line-state inputs, recovers bit timing at the selected rate, assembles 32-bit words, checks odd parity and framing, and presents label/data with a one-cycle write strobe to the 32-bit receive buffer and display path.

## Interface
- F_CLK, 50_000_000: system clock frequency in Hz; bit periods derive from it.
- GAP_BITS, 2: null bit-periods required before a word may start.
- clk  in  1  system clock, all logic on rising edge.
- Rn  in  1  reset, asynchronous, active-low.
- inp1  in  1  line "logic 1" level (TXD1 side), asynchronous.
- inp0  in  1  line "logic 0" level (TXD0 side), asynchronous.
- Nvel  in  2  rate: 00 = 12.5 kbit/s, 01 = 50 kbit/s, 10/11 = 100 kbit/s.
- lbl_val  in  8  label match value (used only with filter, see Configuration).
- lbl_mask  in  8  label match mask, 1 = compare bit.
- rx_adr  out  8  label, bit-reversed: first received bit at rx_adr[7].
- rx_dat  out  24  word bits 9..32, bit 9 at rx_dat[0], parity at rx_dat[23].
- ce_wr  out  1  one-cycle strobe: rx_adr/rx_dat/par_err valid.
- par_err  out  1  1 = received word failed odd parity.
- frm_err  out  1  one-cycle strobe: framing violation detected.
- busy  out  1  1 while a word is being received.

## Operation
- inp1/inp0 pass through 2-FF synchronizers; all decisions use synchronized values s1/s0.
- T = F_CLK / rate clocks per bit (4000/1000/500 at 50 MHz); Q = T/4; timer width $clog2(4000)+1.
- States: SYNC, IDLE, QWAIT, BIT.
- SYNC (reset state): null (s1=s0=0) counter runs; any non-null restarts it. After GAP_BITS*T null clocks -> IDLE.
- IDLE: first non-null clock -> QWAIT, timer cleared, bit count 0, busy=1.
- QWAIT: after Q clocks sample. s1=1,s0=0 -> bit 1; s0=1,s1=0 -> bit 0; null or both high -> frm_err, go SYNC. Valid bit shifts into 32-bit register (first bit to index 0), count+1, -> BIT.
- BIT: wait for next non-null edge (null->non-null) -> QWAIT. If count = 32 after sample: emit word, -> SYNC. If null persists 1.5*T since last edge with count < 32 -> frm_err, -> SYNC.
- Word emit: rx_adr = reverse(bits 1..8), rx_dat = bits 9..32, par_err = ~^word (even count of ones = error); ce_wr pulses. Parity-failed words are still delivered.
- Nvel change takes effect at next IDLE; change mid-word does not corrupt the word in progress (rate latched at IDLE->QWAIT).

## Timing
- Reset: rx_adr=0, rx_dat=0, ce_wr=0, par_err=0, frm_err=0, busy=0, state SYNC; asserting Rn low mid-word discards it, no strobe.
- Input to sample: 2 sync cycles + Q clocks after line edge.
- ce_wr high exactly one clock, in the cycle after the 32nd sample; outputs then hold until next ce_wr.
- frm_err high one clock, in the cycle after the violation is detected; never coincident with ce_wr.
- Word starting less than GAP_BITS*T after previous word end: ignored (SYNC restarts), frm_err pulse once.
- busy falls in the same cycle ce_wr or frm_err rises.

## Configuration
- AR_RX_LABEL_FILTER_EN defined: ce_wr and output update occur only when ((rx_label ^ lbl_val) & lbl_mask) == 0; non-matching words are decoded and parity-checked but silently dropped, outputs hold previous values.
- Undefined: lbl_val/lbl_mask ignored, every complete word strobes.

## Structure
- Shared package ar_pkg: rate encoding constants, state enum, bit-period function of F_CLK/Nvel, WORD_BITS=32, LABEL_BITS=8.
- One sub-module: ar_sync2 (2-FF synchronizer, async active-low reset), instantiated twice.

## Test plan
- 100 kbit/s, label 0o205, data 0x12345, correct parity -> one ce_wr, rx_adr=0x85, rx_dat[22:0]=0x12345, par_err=0.
- Same word with parity bit flipped -> ce_wr, par_err=1, data identical.
- 12.5 kbit/s word, 20 bits then 3T null -> frm_err pulse 1.5T after last edge, no ce_wr, busy=0.
- Both lines high at a sample point -> frm_err, next valid word after 2T gap decoded correctly.
- Rn low at bit 16, released, full word after gap -> no strobe for aborted word, one strobe for the next.
- With AR_RX_LABEL_FILTER_EN, mask 0xFF val 0x85: words with labels 0x85, 0x86 -> exactly one ce_wr, outputs hold 0x85 word.
